// File: rtl/spi_blink_ctrl.sv
// SPI-slave register file (addr, data frames, SPI mode 0) driving an LED blink engine, all in sys_clk.
// Optional register readback on spi_miso is enabled by defining SPI_READBACK_EN.
module spi_blink_ctrl #(
  parameter int unsigned TICK_DIV     = 300000,
  parameter logic [7:0]  DEFAULT_HALF = 8'd50,
  parameter int unsigned SYNC_STAGES  = 2
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       spi_sck,
  input  logic       spi_cs_n,
  input  logic       spi_mosi,
  output logic       spi_miso,
  output logic       led,
  output logic       cfg_en,
  output logic       cfg_inv,
  output logic [7:0] cfg_half_period,
  output logic       wr_strobe,
  output logic       frame_err
);

  localparam int unsigned TICK_W    = $clog2(TICK_DIV);
  localparam logic [7:0]  ADDR_CTRL = 8'h01;
  localparam logic [7:0]  ADDR_HALF = 8'h02;

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic                   r_sck_prev;
  logic                   r_cs_prev;
  logic                   w_sck;
  logic                   w_cs_n;
  logic                   w_mosi;
  logic                   w_sck_rise;
  logic                   w_cs_rise;

  logic [3:0]        r_bit_cnt;
  logic [7:0]        r_shift;
  logic [7:0]        r_addr;
  logic [7:0]        w_byte;
  logic              w_commit;
  logic              w_ctrl_wr;
  logic              w_half_wr;
  logic              r_frame_err;
  logic              r_wr_strobe;
  logic              r_en;
  logic              r_inv;
  logic [7:0]        r_half;

  logic [TICK_W-1:0] r_tick_cnt;
  logic [7:0]        r_half_cnt;
  logic              r_phase;
  logic              r_led;
  logic              w_run;
  logic              w_tick;

  // Input synchronizers; CS idles high so reset does not look like an active frame
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_sck_sync  <= '0;
      r_cs_sync   <= '1;
      r_mosi_sync <= '0;
      r_sck_prev  <= 1'b0;
      r_cs_prev   <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], spi_sck};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], spi_mosi};
      r_sck_prev  <= w_sck;
      r_cs_prev   <= w_cs_n;
    end
  end

  assign w_sck      = r_sck_sync[SYNC_STAGES-1];
  assign w_cs_n     = r_cs_sync[SYNC_STAGES-1];
  assign w_mosi     = r_mosi_sync[SYNC_STAGES-1];
  assign w_sck_rise = w_sck & ~r_sck_prev & ~w_cs_n;
  assign w_cs_rise  = w_cs_n & ~r_cs_prev;

  assign w_byte    = {r_shift[6:0], w_mosi};
  assign w_commit  = w_sck_rise && (r_bit_cnt == 4'd15) && !r_addr[7];
  assign w_ctrl_wr = w_commit && (r_addr == ADDR_CTRL);
  assign w_half_wr = w_commit && (r_addr == ADDR_HALF);

  // Frame shifter: 4-bit counter wraps every 16 bits so frames can stream under one CS
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_bit_cnt   <= 4'd0;
      r_shift     <= 8'd0;
      r_addr      <= 8'd0;
      r_frame_err <= 1'b0;
    end else begin
      r_frame_err <= w_cs_rise && (r_bit_cnt != 4'd0);
      if (w_cs_n) begin
        r_bit_cnt <= 4'd0;
        r_shift   <= 8'd0;
      end else if (w_sck_rise) begin
        r_shift   <= w_byte;
        r_bit_cnt <= r_bit_cnt + 4'd1;
        if (r_bit_cnt == 4'd7) begin
          r_addr <= w_byte;
        end
      end
    end
  end

  // Register file
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_wr_strobe <= 1'b0;
      r_en        <= 1'b1;
      r_inv       <= 1'b0;
      r_half      <= DEFAULT_HALF;
    end else begin
      r_wr_strobe <= w_ctrl_wr || w_half_wr;
      if (w_ctrl_wr) begin
        r_en  <= w_byte[0];
        r_inv <= w_byte[1];
      end
      if (w_half_wr) begin
        r_half <= w_byte;
      end
    end
  end

  assign w_run  = r_en && (r_half != 8'd0);
  assign w_tick = (r_tick_cnt == TICK_W'(TICK_DIV - 1));

  // Blink engine; a HALF_PERIOD write restarts the half count and overrides a coincident toggle
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tick_cnt <= '0;
      r_half_cnt <= 8'd0;
      r_phase    <= 1'b0;
      r_led      <= 1'b0;
    end else begin
      r_led <= r_phase ^ r_inv;
      if (!w_run) begin
        r_tick_cnt <= '0;
        r_half_cnt <= 8'd0;
        r_phase    <= 1'b0;
      end else begin
        r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TICK_W'(1);
        if (w_half_wr) begin
          r_half_cnt <= 8'd0;
        end else if (w_tick) begin
          if (r_half_cnt == r_half - 8'd1) begin
            r_half_cnt <= 8'd0;
            r_phase    <= ~r_phase;
          end else begin
            r_half_cnt <= r_half_cnt + 8'd1;
          end
        end
      end
    end
  end

`ifdef SPI_READBACK_EN
  logic       w_sck_fall;
  logic [7:0] w_rd_val;
  logic [7:0] r_tx;

  assign w_sck_fall = ~w_sck & r_sck_prev & ~w_cs_n;

  always_comb begin
    w_rd_val = 8'h00;
    case (w_byte[6:0])
      7'h01:   w_rd_val = {6'b0, r_inv, r_en};
      7'h02:   w_rd_val = r_half;
      default: w_rd_val = 8'h00;
    endcase
  end

  // Bit7 is presented at the address byte's last rise; falls after the first data rise shift the rest
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_tx <= 8'h00;
    end else if (w_cs_n) begin
      r_tx <= 8'h00;
    end else if (w_sck_rise && (r_bit_cnt == 4'd7)) begin
      r_tx <= w_byte[7] ? w_rd_val : 8'h00;
    end else if (w_sck_fall && (r_bit_cnt >= 4'd9)) begin
      r_tx <= {r_tx[6:0], 1'b0};
    end
  end

  assign spi_miso = r_tx[7];
`else
  assign spi_miso = 1'b0;
`endif

  assign led             = r_led;
  assign cfg_en          = r_en;
  assign cfg_inv         = r_inv;
  assign cfg_half_period = r_half;
  assign wr_strobe       = r_wr_strobe;
  assign frame_err       = r_frame_err;

endmodule

// File: tb/tb_spi_blink_ctrl.sv
// Self-checking bench for spi_blink_ctrl: vector table, hand-written corner sequences, random frames vs model.
`timescale 1ns/1ps
module tb_spi_blink_ctrl;

  localparam int unsigned TICK_DIV = 10;
  localparam int          SCK_HALF = 15;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       spi_sck   = 1'b0;
  logic       spi_cs_n  = 1'b1;
  logic       spi_mosi  = 1'b0;
  logic       spi_miso;
  logic       led;
  logic       cfg_en;
  logic       cfg_inv;
  logic [7:0] cfg_half_period;
  logic       wr_strobe;
  logic       frame_err;

  spi_blink_ctrl #(
    .TICK_DIV     (TICK_DIV),
    .DEFAULT_HALF (8'd50),
    .SYNC_STAGES  (2)
  ) dut (
    .sys_clk         (sys_clk),
    .sys_rst_n       (sys_rst_n),
    .spi_sck         (spi_sck),
    .spi_cs_n        (spi_cs_n),
    .spi_mosi        (spi_mosi),
    .spi_miso        (spi_miso),
    .led             (led),
    .cfg_en          (cfg_en),
    .cfg_inv         (cfg_inv),
    .cfg_half_period (cfg_half_period),
    .wr_strobe       (wr_strobe),
    .frame_err       (frame_err)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks   = 0;
  int n_fail     = 0;
  int strobe_cnt = 0;
  int err_cnt    = 0;
  logic [7:0] rx = 8'h00;

  // Pulse counters: a pulse stretched over N cycles counts N times
  always @(negedge sys_clk) begin
    if (wr_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
    if (frame_err === 1'b1) err_cnt <= err_cnt + 1;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic check_range(input string name, input int act, input int lo, input int hi);
    n_checks++;
    if (act < lo || act > hi) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, act, lo, hi);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge sys_clk);
    #1;
  endtask

  task automatic spi_xfer(input logic [31:0] bits, input int n, input bit release_cs);
    spi_cs_n = 1'b0;
    cycles(6);
    for (int i = 0; i < n; i++) begin
      spi_mosi = bits[31-i];
      cycles(SCK_HALF);
      rx = {rx[6:0], spi_miso};
      spi_sck = 1'b1;
      cycles(SCK_HALF);
      spi_sck = 1'b0;
    end
    cycles(6);
    if (release_cs) begin
      spi_cs_n = 1'b1;
      spi_mosi = 1'b0;
      cycles(10);
    end
  endtask

  task automatic spi_frame(input logic [7:0] a, input logic [7:0] d, input int n);
    spi_xfer({a, d, 16'h0000}, n, 1'b1);
  endtask

  task automatic wait_toggle(input string name, output int cyc, input int budget);
    logic prev;
    prev = led;
    cyc  = 0;
    while (led === prev && cyc < budget) begin
      @(posedge sys_clk);
      #1;
      cyc++;
    end
    if (led === prev) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: led did not toggle within %0d cycles", name, budget);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, " led"}, 32'(led), 32'd0);
    check({tag, " miso"}, 32'(spi_miso), 32'd0);
    check({tag, " cfg_en"}, 32'(cfg_en), 32'd1);
    check({tag, " cfg_inv"}, 32'(cfg_inv), 32'd0);
    check({tag, " cfg_half"}, 32'(cfg_half_period), 32'd50);
    check({tag, " wr_strobe"}, 32'(wr_strobe), 32'd0);
    check({tag, " frame_err"}, 32'(frame_err), 32'd0);
  endtask

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    int         nbits;
    int         d_strobe;
    int         d_err;
    logic       en;
    logic       inv;
    logic [7:0] half;
  } vec_t;

  localparam int NVEC = 13;
  vec_t vecs [NVEC];

  logic       m_en;
  logic       m_inv;
  logic [7:0] m_half;
  int         exp_strobe;
  int         exp_err;
  int         s0;
  int         e0;
  int         cyc;
  int         bad;
  logic [7:0] ra;
  logic [7:0] rd;
  int         rn;
  int         h;
  logic [7:0] exp_rb;

  initial begin
    vecs[0]  = '{8'h02, 8'h03, 16, 1, 0, 1'b1, 1'b0, 8'd3};
    vecs[1]  = '{8'h01, 8'h02, 16, 1, 0, 1'b0, 1'b1, 8'd3};
    vecs[2]  = '{8'h01, 8'h01, 16, 1, 0, 1'b1, 1'b0, 8'd3};
    vecs[3]  = '{8'h02, 8'h0F, 12, 0, 1, 1'b1, 1'b0, 8'd3};
    vecs[4]  = '{8'h02, 8'h07, 16, 1, 0, 1'b1, 1'b0, 8'd7};
    vecs[5]  = '{8'h03, 8'h55, 16, 0, 0, 1'b1, 1'b0, 8'd7};
    vecs[6]  = '{8'h82, 8'h00, 16, 0, 0, 1'b1, 1'b0, 8'd7};
    vecs[7]  = '{8'h00, 8'hFF, 16, 0, 0, 1'b1, 1'b0, 8'd7};
    vecs[8]  = '{8'h02, 8'h09,  8, 0, 1, 1'b1, 1'b0, 8'd7};
    vecs[9]  = '{8'h01, 8'h03, 16, 1, 0, 1'b1, 1'b1, 8'd7};
    vecs[10] = '{8'h02, 8'h00, 16, 1, 0, 1'b1, 1'b1, 8'd0};
    vecs[11] = '{8'h01, 8'h01, 16, 1, 0, 1'b1, 1'b0, 8'd0};
    vecs[12] = '{8'h02, 8'h03, 16, 1, 0, 1'b1, 1'b0, 8'd3};

    // Reset state and first toggle after 50 ticks of 10 cycles
    cycles(3);
    check_reset_values("reset");
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    wait_toggle("first toggle", cyc, 700);
    check_range("first toggle time", cyc, 500, 501);
    check("first toggle level", 32'(led), 32'd1);

    // Register-level vectors
    for (int i = 0; i < NVEC; i++) begin
      s0 = strobe_cnt;
      e0 = err_cnt;
      spi_frame(vecs[i].addr, vecs[i].data, vecs[i].nbits);
      check($sformatf("vec%0d strobe", i), 32'(strobe_cnt - s0), 32'(vecs[i].d_strobe));
      check($sformatf("vec%0d err", i), 32'(err_cnt - e0), 32'(vecs[i].d_err));
      check($sformatf("vec%0d en", i), 32'(cfg_en), 32'(vecs[i].en));
      check($sformatf("vec%0d inv", i), 32'(cfg_inv), 32'(vecs[i].inv));
      check($sformatf("vec%0d half", i), 32'(cfg_half_period), 32'(vecs[i].half));
    end

    // Half period 3 -> toggles every 30 cycles
    wait_toggle("blink3 sync", cyc, 100);
    wait_toggle("blink3 a", cyc, 100);
    check("blink3 interval a", 32'(cyc), 32'(3 * TICK_DIV));
    wait_toggle("blink3 b", cyc, 100);
    check("blink3 interval b", 32'(cyc), 32'(3 * TICK_DIV));

    // Disabled with invert -> led held high; re-enable restarts at phase 0
    spi_frame(8'h01, 8'h02, 16);
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      cycles(1);
      if (led !== 1'b1) bad++;
    end
    check("held led cycles not 1", 32'(bad), 32'd0);
    spi_xfer({8'h01, 8'h01, 16'h0000}, 16, 1'b0);
    check("resume led first", 32'(led), 32'd0);
    check("resume en", 32'(cfg_en), 32'd1);
    wait_toggle("resume first", cyc, 100);
    check("resume toggle level", 32'(led), 32'd1);
    spi_cs_n = 1'b1;
    wait_toggle("resume b", cyc, 100);
    check("resume interval", 32'(cyc), 32'(3 * TICK_DIV));
    cycles(10);

    // Readback frames: no strobe, no register change
`ifdef SPI_READBACK_EN
    exp_rb = 8'h03;
`else
    exp_rb = 8'h00;
`endif
    s0 = strobe_cnt;
    spi_frame(8'h82, 8'h00, 16);
    check("read half miso", 32'(rx), 32'(exp_rb));
`ifdef SPI_READBACK_EN
    exp_rb = 8'h01;
`endif
    spi_frame(8'h81, 8'h00, 16);
    check("read ctrl miso", 32'(rx), 32'(exp_rb));
    spi_frame(8'h85, 8'h00, 16);
    check("read unknown miso", 32'(rx), 32'd0);
    check("read strobe", 32'(strobe_cnt - s0), 32'd0);
    check("read half unchanged", 32'(cfg_half_period), 32'd3);
    check("miso idle", 32'(spi_miso), 32'd0);

    // Two frames streamed under one CS
    s0 = strobe_cnt;
    e0 = err_cnt;
    spi_xfer({8'h02, 8'h04, 8'h01, 8'h01}, 32, 1'b1);
    check("stream strobes", 32'(strobe_cnt - s0), 32'd2);
    check("stream err", 32'(err_cnt - e0), 32'd0);
    check("stream half", 32'(cfg_half_period), 32'd4);

    // Reset in the middle of a frame
    spi_xfer({8'h02, 8'h09, 16'h0000}, 10, 1'b0);
    sys_rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    cycles(3);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    s0 = strobe_cnt;
    e0 = err_cnt;
    cycles(3);
    spi_cs_n = 1'b1;
    cycles(10);
    check("midreset no err", 32'(err_cnt - e0), 32'd0);
    spi_frame(8'h02, 8'h05, 16);
    check("post reset strobe", 32'(strobe_cnt - s0), 32'd1);
    check("post reset half", 32'(cfg_half_period), 32'd5);

    // Random frames against a register-level model
    m_en = 1'b1; m_inv = 1'b0; m_half = 8'd5;
    exp_strobe = strobe_cnt;
    exp_err    = err_cnt;
    for (int i = 0; i < 30; i++) begin
      case ($urandom_range(0, 4))
        0:       ra = 8'h01;
        1:       ra = 8'h02;
        2:       ra = 8'($urandom_range(3, 127));
        3:       ra = 8'h80 | 8'($urandom_range(0, 127));
        default: ra = 8'($urandom);
      endcase
      rd = 8'($urandom);
      rn = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 15)) : 16;
      if (rn == 16) begin
        if (ra == 8'h01) begin
          m_en = rd[0]; m_inv = rd[1]; exp_strobe++;
        end else if (ra == 8'h02) begin
          m_half = rd; exp_strobe++;
        end
      end else begin
        exp_err++;
      end
      spi_frame(ra, rd, rn);
      check($sformatf("rnd%0d strobes", i), 32'(strobe_cnt), 32'(exp_strobe));
      check($sformatf("rnd%0d errs", i), 32'(err_cnt), 32'(exp_err));
      check($sformatf("rnd%0d en", i), 32'(cfg_en), 32'(m_en));
      check($sformatf("rnd%0d inv", i), 32'(cfg_inv), 32'(m_inv));
      check($sformatf("rnd%0d half", i), 32'(cfg_half_period), 32'(m_half));
      if (!m_en || m_half == 8'd0) begin
        check($sformatf("rnd%0d idle led", i), 32'(led), 32'(m_inv));
      end
    end

    // Random half periods: toggle spacing is TICK_DIV*half cycles
    for (int k = 0; k < 3; k++) begin
      h = int'($urandom_range(1, 6));
      spi_frame(8'h02, 8'(h), 16);
      spi_frame(8'h01, 8'h01, 16);
      check($sformatf("rblink%0d half", k), 32'(cfg_half_period), 32'(h));
      wait_toggle("rblink sync", cyc, 2 * TICK_DIV * h + 50);
      wait_toggle("rblink meas", cyc, TICK_DIV * h + 20);
      check($sformatf("rblink%0d interval", k), 32'(cyc), 32'(TICK_DIV * h));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
